// File: rtl/mema_loader_if.sv
// mema_loader_if: groups the loader's control, upstream byte handshake and
// memory write port. The checksum signal exists only when CHECKSUM_EN is defined.
// master: the loader side. slave: the environment (source, memory, controller).
interface mema_loader_if;
  logic       start;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic [2:0] AddrA;
  logic       WEA;
  logic [7:0] DataInA;
  logic       busy;
  logic       load_done;
`ifdef CHECKSUM_EN
  logic [7:0] checksum;

  modport master (
    input  start, in_data, in_valid,
    output in_ready, AddrA, WEA, DataInA, busy, load_done, checksum
  );

  modport slave (
    output start, in_data, in_valid,
    input  in_ready, AddrA, WEA, DataInA, busy, load_done, checksum
  );
`else
  modport master (
    input  start, in_data, in_valid,
    output in_ready, AddrA, WEA, DataInA, busy, load_done
  );

  modport slave (
    output start, in_data, in_valid,
    input  in_ready, AddrA, WEA, DataInA, busy, load_done
  );
`endif
endinterface

// File: rtl/mema_loader.sv
// mema_loader: accepts 8 bytes over a valid/ready handshake after a start
// pulse and writes them to addresses 0..7 of an 8x8 memory, one registered
// write per accepted byte, then pulses load_done.
// Optional build macro CHECKSUM_EN adds a mod-256 checksum of the loaded bytes.
module mema_loader (
  input  logic          clk,
  input  logic          reset,
  mema_loader_if.master bus
);

  typedef enum logic [1:0] {
    StIdle,
    StLoad,
    StFinish
  } state_e;

  state_e     r_state;
  logic [2:0] r_count;
  logic       r_full;
  logic       r_in_ready;
  logic       r_busy;
  logic       r_wea;
  logic [2:0] r_addr;
  logic [7:0] r_data;
  logic       r_load_done;
`ifdef CHECKSUM_EN
  logic [7:0] r_checksum;
`endif

  logic w_accept;
  logic w_last;

  assign w_accept = (r_state == StLoad) && r_in_ready && bus.in_valid;
  assign w_last   = w_accept && (r_count == 3'd7);

  // FSM, byte counter and all registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= StIdle;
      r_count     <= 3'd0;
      r_full      <= 1'b0;
      r_in_ready  <= 1'b0;
      r_busy      <= 1'b0;
      r_wea       <= 1'b0;
      r_addr      <= 3'd0;
      r_data      <= 8'd0;
      r_load_done <= 1'b0;
`ifdef CHECKSUM_EN
      r_checksum  <= 8'd0;
`endif
    end else begin
      r_wea       <= 1'b0;
      r_load_done <= 1'b0;

      if (w_accept) begin
        r_wea  <= 1'b1;
        r_addr <= r_count;
        r_data <= bus.in_data;
`ifdef CHECKSUM_EN
        r_checksum <= r_checksum + bus.in_data;
`endif
      end

      unique case (r_state)
        StIdle: begin
          if (bus.start) begin
            r_state    <= StLoad;
            r_count    <= 3'd0;
            r_full     <= 1'b0;
            r_in_ready <= 1'b1;
            r_busy     <= 1'b1;
`ifdef CHECKSUM_EN
            r_checksum <= 8'd0;
`endif
          end
        end

        StLoad: begin
          // start is deliberately ignored here so an active load never restarts
          if (w_accept) begin
            {r_full, r_count} <= {r_full, r_count} + 4'd1;
          end
          if (w_last) begin
            r_in_ready  <= 1'b0;
            r_load_done <= 1'b1;
            r_state     <= StFinish;
          end
        end

        StFinish: begin
          // This cycle is the load_done cycle; a start here begins the next
          // load immediately so back-to-back loads lose no cycle.
          if (bus.start) begin
            r_state    <= StLoad;
            r_count    <= 3'd0;
            r_full     <= 1'b0;
            r_in_ready <= 1'b1;
            r_busy     <= 1'b1;
`ifdef CHECKSUM_EN
            r_checksum <= 8'd0;
`endif
          end else begin
            r_state    <= StIdle;
            r_in_ready <= 1'b0;
            r_busy     <= 1'b0;
          end
        end

        default: begin
          r_state <= StIdle;
        end
      endcase
    end
  end

  assign bus.in_ready  = r_in_ready;
  assign bus.busy      = r_busy;
  assign bus.WEA       = r_wea;
  assign bus.AddrA     = r_addr;
  assign bus.DataInA   = r_data;
  assign bus.load_done = r_load_done;
`ifdef CHECKSUM_EN
  assign bus.checksum  = r_checksum;
`endif

endmodule
